pipe_chain: RTL and testbench

- Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit registers, each stage carrying its own valid bit.
- Successor to the plain enabled dff chain. Replaces the single global enable with a valid/ready handshake per stage.
- Bubbles collapse, so an empty stage absorbs data even while the output is stalled.
- Supports a synchronous flush and reports occupancy.
- Used between core pipeline stages (IF/ID/EX) and for fixed-latency operand delay.

---
 rtl/pipe_chain_pkg.sv | 15 +
 rtl/pipe_chain_stage.sv | 51 +++++
 rtl/pipe_chain.sv | 81 ++++++++
 tb/tb_pipe_chain.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
`ifndef XLEN
`define XLEN 32
`endif

package pipe_chain_pkg;

    localparam int DEFAULT_DEPTH = 3;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One elastic stage: a data register plus its valid bit. Data only moves on a
// load, so bubbles leave the register untouched.
`ifndef XLEN
`define XLEN 32
`endif

module pipe_stage
    import pipe_chain_pkg::*;
#(
    parameter int               WIDTH     = `XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             ready_in,
    output logic             valid,
    output logic             valid_next,
    output logic [WIDTH-1:0] data
);

    logic ready;
    logic load;

    assign ready = !valid | ready_in;
    assign load  = ready & prev_valid & !flush;

    always_comb begin
        valid_next = valid;
        if (flush)
            valid_next = 1'b0;
        else if (load)
            valid_next = 1'b1;
        else if (valid & ready_in)
            valid_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= valid_next;
            if (load)
                data <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage register chain with per-stage valid/ready, collapsing
// bubbles, synchronous flush and a registered occupancy count.
`ifndef XLEN
`define XLEN 32
`endif

module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int               WIDTH     = `XLEN,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [count_w(DEPTH)-1:0]   count
);

    localparam int CW = count_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_chain: DEPTH must be >= 1");
    end

    logic [DEPTH:0]              rdy;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            vld_nxt;
    logic [DEPTH-1:0]            pv;
    logic [DEPTH-1:0][WIDTH-1:0] pd;
    logic [DEPTH-1:0][WIDTH-1:0] dat;

    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Unrolled ready chain: stage i can accept if out_ready or any stage
        // from i to the head is empty. Avoids a bit-to-bit combinational chain.
        assign rdy[i] = out_ready | ~(&vld[DEPTH-1:i]);

        if (i == 0) begin : g_first
            assign pv[i] = in_valid;
            assign pd[i] = in_data;
        end else begin : g_rest
            assign pv[i] = vld[i-1];
            assign pd[i] = dat[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .prev_valid (pv[i]),
            .prev_data  (pd[i]),
            .ready_in   (rdy[i+1]),
            .valid      (vld[i]),
            .valid_next (vld_nxt[i]),
            .data       (dat[i])
        );
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = vld[DEPTH-1] & !flush;
    assign out_data  = dat[DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= CW'($countones(vld_nxt));
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (WIDTH=32, DEPTH=3): directed scenarios
// plus a randomized valid/ready run against a queue scoreboard.
module tb_pipe_chain;

    localparam int W = 32;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int n_chk = 0;
    int n_pass = 0;

    pipe_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else n_pass++;
        n_chk++; if (count !== 2'd0) $display("FAIL reset_count got=%0d want=0", count); else n_pass++;
        n_chk++; if (out_data !== 32'h0) $display("FAIL reset_out_data got=%h want=0", out_data); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b want=1", in_ready); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        int acc, pop;
        logic ev;
        out_ready = 1'b1;
        for (int c = 0; c < 104; c++) begin
            in_valid = (c < 100);
            in_data  = W'(c);
            tick();
            acc = (c + 1 < 100) ? c + 1 : 100;
            pop = (c >= 3) ? ((c - 2 < 100) ? c - 2 : 100) : 0;
            ev  = (c >= 2 && c <= 101);
            n_chk++; if (out_valid !== ev) $display("FAIL stream_valid c=%0d got=%0b want=%0b", c, out_valid, ev); else n_pass++;
            if (ev) begin
                n_chk++; if (out_data !== W'(c - 2)) $display("FAIL stream_data c=%0d got=%0d want=%0d", c, out_data, c - 2); else n_pass++;
            end
            n_chk++; if (int'(count) !== acc - pop) $display("FAIL stream_count c=%0d got=%0d want=%0d", c, count, acc - pop); else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        do_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = vals[k];
            #1;
            n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_fill_ready k=%0d got=%0b want=1", k, in_ready); else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready k=%0d got=%0b want=0", k, in_ready); else n_pass++;
            n_chk++; if (count !== 2'd3) $display("FAIL bp_stall_count k=%0d got=%0d want=3", k, count); else n_pass++;
            n_chk++; if (out_valid !== 1'b1 || out_data !== 32'hA) $display("FAIL bp_stall_head k=%0d got=%0b/%h want=1/a", k, out_valid, out_data); else n_pass++;
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = vals[3];
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_full_pushpop_ready got=%0b want=1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_chk++; if (count !== 2'd3) $display("FAIL bp_pushpop_count got=%0d want=3", count); else n_pass++;
        for (int k = 1; k < 4; k++) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== vals[k]) $display("FAIL bp_drain k=%0d got=%0b/%h want=1/%h", k, out_valid, out_data, vals[k]); else n_pass++;
            tick();
        end
        n_chk++; if (count !== 2'd0) $display("FAIL bp_drained_count got=%0d want=0", count); else n_pass++;
    endtask

    task automatic test_bubble();
        logic [W-1:0] vals [3] = '{32'h5, 32'h6, 32'h7};
        do_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = vals[0];
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || count !== 2'd1) $display("FAIL bubble_e1 got=%0b/%0d want=0/1", out_valid, count); else n_pass++;
        tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL bubble_e2 got=%0b want=0", out_valid); else n_pass++;
        tick();
        n_chk++; if (out_valid !== 1'b1 || out_data !== vals[0]) $display("FAIL bubble_head got=%0b/%h want=1/5", out_valid, out_data); else n_pass++;
        for (int k = 1; k < 3; k++) begin
            in_valid = 1'b1; in_data = vals[k];
            #1;
            n_chk++; if (in_ready !== 1'b1) $display("FAIL bubble_push_ready k=%0d got=%0b want=1", k, in_ready); else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b0 || count !== 2'd3) $display("FAIL bubble_full got=%0b/%0d want=0/3", in_ready, count); else n_pass++;
        n_chk++; if (out_data !== vals[0]) $display("FAIL bubble_head_held got=%h want=5", out_data); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== vals[k]) $display("FAIL bubble_drain k=%0d got=%0b/%h want=1/%h", k, out_valid, out_data, vals[k]); else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush();
        do_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'h50 + W'(k);
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (count !== 2'd3) $display("FAIL flush_prefill_count got=%0d want=3", count); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b want=0", in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%0b want=0", out_valid); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (count !== 2'd0) $display("FAIL flush_count got=%0d want=0", count); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_leak k=%0d got=%0b/%h want=0", k, out_valid, out_data); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h100 + W'(k);
            tick();
        end
        n_chk++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid got=%0b want=1", out_valid); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid got=%0b want=0", out_valid); else n_pass++;
        n_chk++; if (count !== 2'd0) $display("FAIL areset_count got=%0d want=0", count); else n_pass++;
        n_chk++; if (out_data !== 32'h0) $display("FAIL areset_out_data got=%h want=0", out_data); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got=%0b want=1", in_ready); else n_pass++;
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL areset_after got=%0b/%0d want=0/0", out_valid, count); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        int acc = 0;
        int cyc = 0;
        logic fl, exp_ir;
        do_flush();
        while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
            fl        = ($urandom_range(0, 99) < 2);
            flush     = fl;
            in_valid  = (acc < 1000) && ($urandom_range(0, 99) < 70);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ir = !fl && (q.size() < D || out_ready);
            n_chk++; if (in_ready !== exp_ir) $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", cyc, in_ready, exp_ir); else n_pass++;
            n_chk++; if (int'(count) !== q.size()) $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, count, q.size()); else n_pass++;
            n_chk++; if (int'(count) > D) $display("FAIL rnd_count_max cyc=%0d got=%0d want<=%0d", cyc, count, D); else n_pass++;
            if (fl) begin
                n_chk++; if (out_valid !== 1'b0) $display("FAIL rnd_flush_valid cyc=%0d got=%0b want=0", cyc, out_valid); else n_pass++;
            end else if (out_valid === 1'b1) begin
                n_chk++;
                if (q.size() == 0) $display("FAIL rnd_spurious cyc=%0d got=%h want=empty", cyc, out_data);
                else if (out_data !== q[0]) $display("FAIL rnd_order cyc=%0d got=%h want=%h", cyc, out_data, q[0]);
                else n_pass++;
            end
            if (fl) q.delete();
            else begin
                if (out_valid === 1'b1 && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready === 1'b1) begin
                    q.push_back(in_data);
                    acc++;
                end
            end
            tick();
            cyc++;
        end
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (cyc >= 20000) $display("FAIL rnd_timeout got=%0d cycles want<20000 (pending=%0d)", cyc, q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
